// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter/sequencer for a single-port data memory
// One access per grant: IDLE picks a winner, ACCESS drives memory, RESP pulses done.
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wr_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state;
  logic   rr_ptr;
  logic   lat_port;
  logic   lat_we;
  logic   lat_oor;

  logic              pick1;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;
  logic              pick_oor;

  // Port 1 wins when it is the only requester or when it holds the round-robin turn.
  assign pick1      = req1_valid & (~req0_valid | rr_ptr);
  assign pick_we    = pick1 ? req1_we    : req0_we;
  assign pick_addr  = pick1 ? req1_addr  : req0_addr;
  assign pick_wdata = pick1 ? req1_wdata : req0_wdata;
  assign pick_oor   = pick_addr >= ADDR_W'(MEM_DEPTH);

  assign busy = (state != IDLE);

  // mem_addr/mem_write_data double as the latched request fields during ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      rr_ptr         <= 1'b0;
      lat_port       <= 1'b0;
      lat_we         <= 1'b0;
      lat_oor        <= 1'b0;
      mem_wr_rd_en   <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      err0           <= 1'b0;
      err1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            lat_port       <= pick1;
            lat_we         <= pick_we;
            lat_oor        <= pick_oor;
            rr_ptr         <= ~pick1;
            mem_addr       <= pick_addr;
            mem_write_data <= pick_wdata;
            mem_wr_rd_en   <= pick_we & ~pick_oor;
            state          <= ACCESS;
          end
        end
        ACCESS: begin
          mem_wr_rd_en   <= 1'b0;
          mem_addr       <= '0;
          mem_write_data <= '0;
          state          <= RESP;
          if (lat_port) begin
            done1 <= 1'b1;
            err1  <= lat_oor;
            if (lat_oor)      rdata1 <= '0;
            else if (!lat_we) rdata1 <= mem_read_data;
          end else begin
            done0 <= 1'b1;
            err0  <= lat_oor;
            if (lat_oor)      rdata0 <= '0;
            else if (!lat_we) rdata0 <= mem_read_data;
          end
        end
        RESP: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
// Includes a 32-word behavioural memory with combinational read.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        done0, err0, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_wr_rd_en, busy;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .mem_wr_rd_en(mem_wr_rd_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:31];
  bit loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h11;
      mem[2] <= 32'h22;
      mem[3] <= 32'h33;
      mem[7] <= 32'h77;
      loaded <= 1'b1;
    end else if (mem_wr_rd_en && mem_addr < 32) begin
      mem[mem_addr[4:0]] <= mem_write_data;
    end
  end

  assign mem_read_data = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-port transaction; lat is the negedge count from issue to done (-1 on timeout).
  task automatic txn(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat, output int en_cnt, output logic [31:0] rd,
                     output logic er, output int other_done);
    @(negedge clk);
    if (port) begin
      req1_we = we; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
    end else begin
      req0_we = we; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
    end
    lat = -1; en_cnt = 0; other_done = 0; rd = 32'hx; er = 1'bx;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1 if (mem_wr_rd_en) en_cnt++;
      @(negedge clk);
      if (port ? done0 : done1) other_done++;
      if (port ? done1 : done0) begin
        lat = c;
        rd  = port ? rdata1 : rdata0;
        er  = port ? err1 : err0;
        break;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  int lat, en_cnt, other_done, t0, t1;
  logic [31:0] rd;
  logic er;

  initial begin
    rst = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd1; req0_wdata = 32'h0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'd2; req1_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_done0", done0, 0);
    check("rst_done1", done1, 0);
    check("rst_err0", err0, 0);
    check("rst_err1", err1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_busy", busy, 0);
    check("rst_wren", mem_wr_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_write_data, 0);
    rst = 1'b1;

    // Sustained contention: done0 at cycles 2,8 and done1 at 5,11.
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("cont_done0_c%0d", k), done0, (k % 6 == 2));
      check($sformatf("cont_done1_c%0d", k), done1, (k % 6 == 5));
      if (k == 1) check("cont_first_addr", mem_addr, 32'd1);
      if (k % 6 == 2) check($sformatf("cont_rdata0_c%0d", k), rdata0, 32'h11);
      if (k % 6 == 5) check($sformatf("cont_rdata1_c%0d", k), rdata1, 32'h22);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, lat, en_cnt, rd, er, other_done);
    check("wr5_latency", lat, 2);
    check("wr5_en_cycles", en_cnt, 1);
    check("wr5_err", er, 0);
    check("wr5_other_done", other_done, 0);
    check("wr5_mem", mem[5], 32'hDEADBEEF);

    txn(1'b0, 1'b0, 32'd5, 32'h0, lat, en_cnt, rd, er, other_done);
    check("rd5_latency", lat, 2);
    check("rd5_data", rd, 32'hDEADBEEF);
    check("rd5_err", er, 0);
    check("rd5_en_cycles", en_cnt, 0);

    txn(1'b1, 1'b1, 32'd32, 32'hBAD0BAD0, lat, en_cnt, rd, er, other_done);
    check("oor_latency", lat, 2);
    check("oor_en_cycles", en_cnt, 0);
    check("oor_err", er, 1);
    check("oor_rdata", rd, 0);
    check("oor_mem0", mem[0], 0);
    @(negedge clk);
    check("oor_err_after", err1, 0);

    // Coherence: port 0 holds the turn, so its read sees the pre-write value.
    req0_we = 1'b0; req0_addr = 32'd7; req0_wdata = 32'h0; req0_valid = 1'b1;
    req1_we = 1'b1; req1_addr = 32'd7; req1_wdata = 32'hA5A5A5A5; req1_valid = 1'b1;
    t0 = -1; t1 = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done0) begin t0 = c; check("coh_rd_old", rdata0, 32'h77); req0_valid = 1'b0; end
      if (done1) begin t1 = c; req1_valid = 1'b0; end
      if (t0 > 0 && t1 > 0) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("coh_done0_cycle", t0, 2);
    check("coh_done1_cycle", t1, 5);
    txn(1'b0, 1'b0, 32'd7, 32'h0, lat, en_cnt, rd, er, other_done);
    check("coh_rd_new", rd, 32'hA5A5A5A5);

    // Reset during the ACCESS cycle of a write.
    @(negedge clk);
    req0_we = 1'b1; req0_addr = 32'd3; req0_wdata = 32'hCAFEF00D; req0_valid = 1'b1;
    @(posedge clk);
    #2 check("rstw_en_before", mem_wr_rd_en, 1);
    rst = 1'b0;
    #1 check("rstw_en_async", mem_wr_rd_en, 0);
    req0_valid = 1'b0;
    t0 = 0;
    repeat (2) begin
      @(negedge clk);
      if (done0) t0++;
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done0) t0++;
    end
    check("rstw_no_done", t0, 0);
    check("rstw_busy", busy, 0);
    check("rstw_mem3", mem[3], 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
